dpd_stream_codec: RTL and testbench
===================================

# dpd_stream_codec

Parametrised, streaming successor to the single-declet combinational DPD packer. Packs a serial stream of BCD digits into a word of `DECLETS` Densely Packed Decimal declets, or unpacks such a word back into a serial BCD digit stream. The mode is selected per transaction. Both sides use valid/ready handshakes. The block sits between a digit-serial front end (keypad, UART, display scanner) and word-wide decimal storage or datapath logic.

## Interface
Parameters:
- `DECLETS`, default 2: declets per word; the word holds 3*DECLETS digits and is 10*DECLETS bits wide. Legal range 1..8.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `mode` input 1: 0 = pack, 1 = unpack; sampled on the first input handshake of a transaction.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block accepts an input beat.
- `in_digit` input 4: BCD digit, pack mode only.
- `in_word` input 10*DECLETS: DPD word, unpack mode only.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: consumer accepts the output beat.
- `out_word` output 10*DECLETS: packed word in pack mode; 0 in unpack mode.
- `out_digit` output 4: unpacked digit in unpack mode; 0 in pack mode.
- `out_last` output 1: final beat of a transaction (always 1 on a pack result).
- `out_err` output 1: pack result contained at least one digit greater than 9.

## Operation
- A handshake occurs on a rising edge where both valid and ready are 1.
- States:
  - `S_IN`: `in_ready`=1, `out_valid`=0.
  - `S_PACK_OUT`: `out_valid`=1.
  - `S_UNPACK_OUT`: `out_valid`=1.
- Pack mode:
  - Digits are accepted most-significant first, one per handshake. A digit counter runs 0..3*DECLETS-1.
  - When the third digit of a triplet is accepted, that triplet is encoded into a declet with the standard IEEE 754-2008 DPD equations. The declet is stored into its slot; declet 0 (first triplet) occupies the MSBs.
  - Acceptance of digit 3*DECLETS-1 moves the FSM to `S_PACK_OUT` with `out_word` complete and `out_last`=1.
  - On the output handshake the FSM returns to `S_IN`, and the counter and the error flag clear.
- Invalid digits (0xA–0xF) are still encoded: the raw nibble bits feed the equations. They set the sticky `out_err` for that word.
- Unpack mode:
  - One `in_word` is captured on the input handshake; the FSM moves to `S_UNPACK_OUT`.
  - Digits are emitted most-significant first, one per output handshake: declet 0 hundreds, tens, ones, then declet 1, and so on.
  - `out_last`=1 on digit 3*DECLETS-1. Its handshake returns the FSM to `S_IN`.
  - Decoding follows the standard DPD decode. Don't-care bits of non-canonical declets are ignored, e.g. 0x3FF decodes to 9,9,9.
  - `out_err`=0 throughout unpack mode.
- `mode` is ignored except on the first input beat of a transaction; changes mid-transaction have no effect.
- `in_word` is ignored in pack mode, and `in_digit` in unpack mode.

## Timing
- After a reset edge: state `S_IN`, digit counter 0, `in_ready`=1, `out_valid`=0, `out_word`=0, `out_digit`=0, `out_last`=0, `out_err`=0.
- `rst` asserted mid-transaction discards all partial digits and words on that edge, with no output.
- `in_ready` and `out_valid` are registered-state decodes. There are no combinational paths from `in_valid`/`out_ready` to `in_ready`/`out_valid`.
- Pack latency: `out_valid` rises the cycle after the last digit handshake. Peak throughput is one word per 3*DECLETS+1 cycles; the return to `S_IN` costs one cycle.
- Unpack latency: the first digit is valid the cycle after the word handshake. Each further digit is valid the cycle after the previous output handshake. Peak rate is 1 word per 3*DECLETS+1 cycles.
- Outputs are held stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` gaps between pack digits are allowed indefinitely and do not advance the counter.

## Test plan
- Pack, DECLETS=2, `mode`=0, digits 1,2,3,4,5,6 back-to-back with `out_ready`=1. Required: `out_word`=0x28E56, `out_last`=1, `out_err`=0, `out_valid` high exactly one cycle after the 6th accept.
- Pack digits 9,9,9,0,0,0 with `out_ready` held low 5 cycles. Required: `out_word`=0x3FC00 stable throughout; `in_ready`=0 until the cycle after the handshake.
- Unpack `in_word`=0x28E56. Required: digits 1,2,3,4,5,6 on successive handshakes, `out_last` only on 6. With random `out_ready` stalls, sequence unchanged.
- Unpack non-canonical `in_word`=0x3FF_3FF (DECLETS=2). Required: digits 9,9,9,9,9,9.
- Pack digits 0xA,0,0,0,0,1. Required: `out_err`=1 on the result; the next word 0,0,0,0,0,1 yields `out_word`=0x00001, `out_err`=0.
- Feed 3 digits, assert `rst` one cycle, then feed 1..6. Required: post-reset outputs at reset values; result 0x28E56. Also toggle `mode` mid-pack: result unaffected.

Source files
------------

// File: rtl/dpd_stream_codec.sv
// Streaming BCD <-> Densely Packed Decimal codec: packs a serial digit stream into
// DECLETS declets per word, or unpacks such a word back into serial digits.
module dpd_stream_codec #(
    parameter int DECLETS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_digit,
    input  logic [10*DECLETS-1:0]  in_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [10*DECLETS-1:0]  out_word,
    output logic [3:0]             out_digit,
    output logic                   out_last,
    output logic                   out_err
);
    // state        | meaning
    // S_IN         | accepting digits (pack) or the first beat of a new transaction
    // S_PACK_OUT   | packed word presented, waiting for consumer
    // S_UNPACK_OUT | emitting unpacked digits, one per output handshake

    localparam int W  = 10 * DECLETS;
    localparam int SW = (DECLETS > 1) ? $clog2(DECLETS) : 1;

    typedef enum logic [1:0] {S_IN, S_PACK_OUT, S_UNPACK_OUT} state_t;

    state_t         state, state_nx;
    logic [SW-1:0]  slot;
    logic [1:0]     pos;
    logic [3:0]     d_hi, d_mid;
    logic [W-1:0]   word_q;
    logic           err_q;

    logic           first_beat, last_digit, start_unpack, advance;
    logic [9:0]     cur_declet;
    logic [11:0]    cur_triplet;

    // Raw nibble bits feed the equations, so invalid digits still encode deterministically.
    function automatic logic [9:0] dpd_encode(input logic [3:0] h, input logic [3:0] t,
                                              input logic [3:0] o);
        logic [9:0] r;
        case ({h[3], t[3], o[3]})
            3'b000:  r = {h[2:0], t[2:0], 1'b0, o[2:0]};
            3'b001:  r = {h[2:0], t[2:0], 1'b1, 2'b00, o[0]};
            3'b010:  r = {h[2:0], o[2:1], t[0], 1'b1, 2'b01, o[0]};
            3'b100:  r = {o[2:1], h[0], t[2:0], 1'b1, 2'b10, o[0]};
            3'b110:  r = {o[2:1], h[0], 2'b00, t[0], 1'b1, 2'b11, o[0]};
            3'b101:  r = {t[2:1], h[0], 2'b01, t[0], 1'b1, 2'b11, o[0]};
            3'b011:  r = {h[2:0], 2'b10, t[0], 1'b1, 2'b11, o[0]};
            default: r = {2'b00, h[0], 2'b11, t[0], 1'b1, 2'b11, o[0]};
        endcase
        return r;
    endfunction

    // Returns {hundreds, tens, ones}; don't-care bits of non-canonical declets are dropped.
    function automatic logic [11:0] dpd_decode(input logic [9:0] x);
        logic [11:0] r;
        if (!x[3]) begin
            r = {1'b0, x[9:7], 1'b0, x[6:4], 1'b0, x[2:0]};
        end else begin
            case (x[2:1])
                2'b00:   r = {1'b0, x[9:7], 1'b0, x[6:4], 3'b100, x[0]};
                2'b01:   r = {1'b0, x[9:7], 3'b100, x[4], 1'b0, x[6:5], x[0]};
                2'b10:   r = {3'b100, x[7], 1'b0, x[6:4], 1'b0, x[9:8], x[0]};
                default: begin
                    case (x[6:5])
                        2'b00:   r = {3'b100, x[7], 3'b100, x[4], 1'b0, x[9:8], x[0]};
                        2'b01:   r = {3'b100, x[7], 1'b0, x[9:8], x[4], 3'b100, x[0]};
                        2'b10:   r = {1'b0, x[9:7], 3'b100, x[4], 3'b100, x[0]};
                        default: r = {3'b100, x[7], 3'b100, x[4], 3'b100, x[0]};
                    endcase
                end
            endcase
        end
        return r;
    endfunction

    assign first_beat   = (slot == '0) && (pos == 2'd0);
    assign last_digit   = (slot == SW'(DECLETS - 1)) && (pos == 2'd2);
    assign start_unpack = (state == S_IN) && in_valid && first_beat && mode;
    assign advance      = ((state == S_IN) && in_valid && !start_unpack) ||
                          ((state == S_UNPACK_OUT) && out_ready);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (first_beat && mode) state_nx = S_UNPACK_OUT;
                    else if (last_digit)    state_nx = S_PACK_OUT;
                end
            end
            S_PACK_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IN;
            end
            S_UNPACK_OUT: begin
                out_valid = 1'b1;
                if (out_ready && last_digit) state_nx = S_IN;
            end
            default: state_nx = S_IN;
        endcase
    end

    // Declet 0 lives in the MSBs, so slot i maps to bit field DECLETS-1-i.
    always_comb begin
        cur_declet = '0;
        for (int i = 0; i < DECLETS; i++) begin
            if (slot == SW'(i)) cur_declet = word_q[(DECLETS-1-i)*10 +: 10];
        end
        cur_triplet = dpd_decode(cur_declet);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot   <= '0;
            pos    <= 2'd0;
            d_hi   <= 4'd0;
            d_mid  <= 4'd0;
            word_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (start_unpack) word_q <= in_word;

            if ((state == S_IN) && in_valid && !start_unpack) begin
                err_q <= err_q | (in_digit > 4'd9);
                if (pos == 2'd0) d_hi  <= in_digit;
                if (pos == 2'd1) d_mid <= in_digit;
                if (pos == 2'd2) begin
                    for (int i = 0; i < DECLETS; i++) begin
                        if (slot == SW'(i))
                            word_q[(DECLETS-1-i)*10 +: 10] <= dpd_encode(d_hi, d_mid, in_digit);
                    end
                end
            end

            if ((state == S_PACK_OUT) && out_ready) err_q <= 1'b0;

            if (advance) begin
                if (pos == 2'd2) begin
                    pos  <= 2'd0;
                    slot <= last_digit ? '0 : slot + SW'(1);
                end else begin
                    pos <= pos + 2'd1;
                end
            end
        end
    end

    always_comb begin
        out_word  = '0;
        out_digit = 4'd0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        if (state == S_PACK_OUT) begin
            out_word = word_q;
            out_last = 1'b1;
            out_err  = err_q;
        end else if (state == S_UNPACK_OUT) begin
            out_last = last_digit;
            case (pos)
                2'd0:    out_digit = cur_triplet[11:8];
                2'd1:    out_digit = cur_triplet[7:4];
                default: out_digit = cur_triplet[3:0];
            endcase
        end
    end

endmodule

// File: tb/tb_dpd_stream_codec.sv
// Self-checking bench for dpd_stream_codec (DECLETS=2): directed and randomized
// pack/unpack transactions against a field-arithmetic DPD reference model.
module tb_dpd_stream_codec;
    localparam int N = 6;

    logic        clk = 1'b0;
    logic        rst, mode, in_valid, in_ready, out_valid, out_ready, out_last, out_err;
    logic [3:0]  in_digit, out_digit;
    logic [19:0] in_word, out_word;

    int vectors = 0;
    int miscompares = 0;
    int dig [N];

    dpd_stream_codec #(.DECLETS(2)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_digit(out_digit), .out_last(out_last), .out_err(out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
        end
    endtask

    // Declet as three bit fields (hi<<7 | mid<<4 | v<<3 | low) chosen by which digits are large.
    function automatic int enc(input int h, input int t, input int o);
        int ind, hi, mid, low, v;
        ind = ((h / 8) % 2) * 4 + ((t / 8) % 2) * 2 + ((o / 8) % 2);
        v   = (ind == 0) ? 0 : 1;
        hi  = h % 8;  mid = t % 8;  low = o % 8;
        case (ind)
            1: low = o % 2;
            2: begin mid = (o % 8) / 2 * 2 + t % 2; low = 2 + o % 2; end
            4: begin hi = (o % 8) / 2 * 2 + h % 2; low = 4 + o % 2; end
            6: begin hi = (o % 8) / 2 * 2 + h % 2; mid = t % 2; low = 6 + o % 2; end
            5: begin hi = (t % 8) / 2 * 2 + h % 2; mid = 2 + t % 2; low = 6 + o % 2; end
            3: begin mid = 4 + t % 2; low = 6 + o % 2; end
            7: begin hi = h % 2; mid = 6 + t % 2; low = 6 + o % 2; end
            default: ;
        endcase
        return hi * 128 + mid * 16 + v * 8 + low;
    endfunction

    function automatic int model_word();
        return enc(dig[0], dig[1], dig[2]) * 1024 + enc(dig[3], dig[4], dig[5]);
    endfunction

    task automatic wait_in_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, in_ready, 1'b1);
    endtask

    task automatic send_digit(input int d, input logic m, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_digit = 4'(d);
        mode     = m;
        in_word  = 20'($urandom);
        wait_in_ready("in_ready_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pack_txn(input string tag, input int max_gap, input int stall, input bit toggle);
        int exp_w;
        int exp_e;
        exp_w = model_word();
        exp_e = 0;
        for (int k = 0; k < N; k++) if (dig[k] > 9) exp_e = 1;
        for (int k = 0; k < N; k++)
            send_digit(dig[k], (toggle && k > 0) ? 1'($urandom) : 1'b0,
                       $urandom_range(0, max_gap));
        chk({tag, "_latency"}, out_valid, 1'b1);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, "_hold_word"}, out_word, exp_w);
            chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_word"}, out_word, exp_w);
        chk({tag, "_last"}, out_last, 1'b1);
        chk({tag, "_err"}, out_err, exp_e);
        chk({tag, "_digit0"}, out_digit, 4'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ret_in_ready"}, in_ready, 1'b1);
        chk({tag, "_ret_valid"}, out_valid, 1'b0);
    endtask

    task automatic unpack_txn(input string tag, input logic [19:0] w, input int max_stall);
        @(negedge clk);
        in_valid = 1'b1;
        mode     = 1'b1;
        in_word  = w;
        in_digit = 4'($urandom);
        wait_in_ready("in_ready_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode     = 1'b0;
        chk({tag, "_latency"}, out_valid, 1'b1);
        chk({tag, "_busy"}, in_ready, 1'b0);
        for (int k = 0; k < N; k++) begin
            int st;
            st = $urandom_range(0, max_stall);
            for (int s = 0; s < st; s++) begin
                @(negedge clk);
                chk({tag, "_hold_digit"}, out_digit, dig[k]);
            end
            @(negedge clk);
            chk({tag, "_valid"}, out_valid, 1'b1);
            chk({tag, "_digit"}, out_digit, dig[k]);
            chk({tag, "_last"}, out_last, (k == N - 1) ? 1'b1 : 1'b0);
            chk({tag, "_err"}, out_err, 1'b0);
            chk({tag, "_word0"}, out_word, 20'd0);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        chk({tag, "_ret_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_word"}, out_word, 20'd0);
        chk({tag, "_out_digit"}, out_digit, 4'd0);
        chk({tag, "_out_last"}, out_last, 1'b0);
        chk({tag, "_out_err"}, out_err, 1'b0);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_digit = 4'd0;
        in_word = 20'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");

        dig = '{1, 2, 3, 4, 5, 6};
        chk("model_123456", 32'(model_word()), 32'h28E56);
        pack_txn("pack_123456", 0, 0, 1'b0);

        dig = '{9, 9, 9, 0, 0, 0};
        pack_txn("pack_999000", 0, 5, 1'b0);

        dig = '{1, 2, 3, 4, 5, 6};
        unpack_txn("unpack_28E56", 20'h28E56, 3);

        dig = '{9, 9, 9, 9, 9, 9};
        unpack_txn("unpack_noncanon", 20'hFFFFF, 2);

        dig = '{10, 0, 0, 0, 0, 1};
        pack_txn("pack_invalid", 1, 1, 1'b0);
        dig = '{0, 0, 0, 0, 0, 1};
        pack_txn("pack_after_err", 0, 0, 1'b0);
        chk("model_000001", 32'(model_word()), 32'h00001);

        send_digit(7, 1'b0, 0);
        send_digit(8, 1'b0, 0);
        send_digit(9, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("midreset");
        dig = '{1, 2, 3, 4, 5, 6};
        pack_txn("pack_after_rst", 0, 0, 1'b1);

        for (int r = 0; r < 14; r++) begin
            for (int k = 0; k < N; k++)
                dig[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15))
                                                    : int'($urandom_range(0, 9));
            pack_txn("pack_rand", 3, $urandom_range(0, 3), 1'b1);
        end

        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < N; k++) dig[k] = $urandom_range(0, 9);
            unpack_txn("unpack_rand", 20'(model_word()), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
